// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the fetch stage. Holds the PC register and a
// hardware return-address stack. One PC update per enabled cycle, selected by
// priority: ret > call > load > increment > relative branch (no strobe).
//
// Parameters
//   PC_W          PC, in, offset and stack entry width
//   DEPTH         return-address stack entries (>= 2)
//   STEP          increment amount, also the call return-address offset
//   RESET_VECTOR  PC value after reset
//   PC_LIMIT      highest legal PC (bounds build only)
//   FAULT_VECTOR  PC forced on a bounds fault (bounds build only)
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high; overrides enable
//   enable           1 = apply the selected op, 0 = hold all state
//   ret              pop stack, PC <= popped address
//   call             push PC+STEP, PC <= in
//   load             PC <= in
//   increment        PC <= PC+STEP
//   offset           signed branch displacement, used when no strobe is set
//   in               absolute target for load/call
//   out              current PC (registered)
//   ret_addr         top-of-stack entry, 0 when empty
//   stack_depth      number of valid entries, 0..DEPTH
//   stack_full       stack_depth == DEPTH
//   stack_empty      stack_depth == 0
//   stack_overflow   sticky: call issued while full
//   stack_underflow  sticky: ret issued while empty
//   pc_fault         sticky bounds fault (tied 0 in the default build)
//
// Build option
//   PC_BOUNDS_EN     when defined, a resolved next PC above PC_LIMIT is
//                    replaced by FAULT_VECTOR and pc_fault is set. Stack
//                    side-effects of the op still take place.
// -----------------------------------------------------------------------------
module pc_stack_unit #(
   parameter int unsigned     PC_W         = 16,
   parameter int unsigned     DEPTH        = 8,
   parameter logic [PC_W-1:0] STEP         = PC_W'(1),
   parameter logic [PC_W-1:0] RESET_VECTOR = '0,
   parameter logic [PC_W-1:0] PC_LIMIT     = '1,
   parameter logic [PC_W-1:0] FAULT_VECTOR = PC_W'(1),
   localparam int unsigned    DEPTH_W      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               ret,
   input  logic               call,
   input  logic               load,
   input  logic               increment,
   input  logic [PC_W-1:0]    offset,
   input  logic [PC_W-1:0]    in,
   output logic [PC_W-1:0]    out,
   output logic [PC_W-1:0]    ret_addr,
   output logic [DEPTH_W-1:0] stack_depth,
   output logic               stack_full,
   output logic               stack_empty,
   output logic               stack_overflow,
   output logic               stack_underflow,
   output logic               pc_fault
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_RET,
      OP_CALL,
      OP_LOAD,
      OP_INC,
      OP_BRANCH
   } op_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic [PC_W-1:0]    stack_q [DEPTH];

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   op_e             op;
   logic            is_empty;
   logic            is_full;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] push_idx;
   logic [PC_W-1:0] top_entry;
   logic [PC_W-1:0] pc_step;
   logic [PC_W-1:0] pc_branch;
   logic [PC_W-1:0] pc_next;     // PC after op resolution, before bounds check
   logic            push_we;

   assign is_empty  = (depth_q == '0);
   assign is_full   = (depth_q == DEPTH_W'(DEPTH));
   // Only meaningful when not empty; the wrap at depth 0 is never consumed.
   assign top_idx   = PTR_W'(depth_q - DEPTH_W'(1));
   // Only meaningful when not full, so depth_q always fits the pointer.
   assign push_idx  = PTR_W'(depth_q);
   assign top_entry = stack_q[top_idx];

   // Unsigned add of a two's-complement offset gives the signed branch target
   // modulo 2^PC_W; wrap-around is intentional and silent.
   assign pc_step   = pc_q + STEP;
   assign pc_branch = pc_q + offset;

   // Strobe priority: lower-priority strobes are ignored when a higher one is set.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
      op = OP_BRANCH;
      if (ret) begin
         op = OP_RET;
      end else if (call) begin
         op = OP_CALL;
      end else if (load) begin
         op = OP_LOAD;
      end else if (increment) begin
         op = OP_INC;
      end
   end

   // Next-state for PC, depth and sticky stack flags.
   always_comb begin
      pc_next     = pc_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      push_we     = 1'b0;

      if (enable) begin
         unique case (op)
            OP_RET: begin
               if (!is_empty) begin
                  pc_next = top_entry;
                  depth_d = depth_q - DEPTH_W'(1);
               end else begin
                  // Empty-stack return falls through as a plain increment.
                  pc_next     = pc_step;
                  underflow_d = 1'b1;
               end
            end
            OP_CALL: begin
               pc_next = in;
               if (!is_full) begin
                  push_we = 1'b1;
                  depth_d = depth_q + DEPTH_W'(1);
               end else begin
                  // The jump still happens; only the push is dropped.
                  overflow_d = 1'b1;
               end
            end
            OP_LOAD:   pc_next = in;
            OP_INC:    pc_next = pc_step;
            OP_BRANCH: pc_next = pc_branch;
            default:   pc_next = pc_q;
         endcase
      end
   end

`ifdef PC_BOUNDS_EN
   // ---------------------------------------------------------------------------
   // Bounds check on the resolved PC. FAULT_VECTOR is used as-is, unchecked.
   // ---------------------------------------------------------------------------
   logic pc_fault_q, pc_fault_d;

   always_comb begin
      pc_d       = pc_next;
      pc_fault_d = pc_fault_q;
      if (enable && (pc_next > PC_LIMIT)) begin
         pc_d       = FAULT_VECTOR;
         pc_fault_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_fault_q <= 1'b0;
      end else begin
         pc_fault_q <= pc_fault_d;
      end
   end

   assign pc_fault = pc_fault_q;
`else
   // Bounds feature compiled out: PC passes straight through, no fault flag.
   logic unused_bounds_cfg;

   assign pc_d              = pc_next;
   assign pc_fault          = 1'b0;
   assign unused_bounds_cfg = ^{PC_LIMIT, FAULT_VECTOR};
`endif

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         pc_q        <= RESET_VECTOR;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: the stack array has no reset; entries above depth_q are never observed, so clearing them would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (!reset && push_we) begin
         stack_q[push_idx] <= pc_step;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign out             = pc_q;
   assign ret_addr        = is_empty ? '0 : top_entry;
   assign stack_depth     = depth_q;
   assign stack_full      = is_full;
   assign stack_empty     = is_empty;
   assign stack_overflow  = overflow_q;
   assign stack_underflow = underflow_q;

endmodule
